// File: rtl/multi_edge_detector.sv
// Per-channel synchronizer, stability-count glitch filter and mode-qualified edge detector
// with sticky write-1-to-clear status flags and a registered interrupt summary.
module multi_edge_detector #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     level_in,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     irq_en,
  input  logic [WIDTH-1:0]     clr,
  output logic [WIDTH-1:0]     filt_level,
  output logic [WIDTH-1:0]     edge_pulse,
  output logic [WIDTH-1:0]     status,
  output logic                 irq
);

  localparam int unsigned CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_i;

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] filt_q,   filt_d;
  logic [WIDTH-1:0] pulse_q,  pulse_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic             irq_q,    irq_d;
  mode_e            ch_mode;

  assign sync_i = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= level_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // The counter runs only while the synchronized input disagrees with the filtered
  // level; mode is looked at only on the edge that commits the toggle.
  always_comb begin
    filt_d  = filt_q;
    pulse_d = '0;
    ch_mode = MODE_OFF;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_i[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync_i[i];
          ch_mode   = mode_e'(mode[2*i +: 2]);
          case (ch_mode)
            MODE_RISE: pulse_d[i] = sync_i[i];
            MODE_FALL: pulse_d[i] = ~sync_i[i];
            MODE_BOTH: pulse_d[i] = 1'b1;
            default:   pulse_d[i] = 1'b0;
          endcase
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    status_d = (status_q & ~clr) | pulse_q;
    irq_d    = |(status_q & irq_en);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      filt_q   <= '0;
      pulse_q  <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      filt_q   <= filt_d;
      pulse_q  <= pulse_d;
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign filt_level = filt_q;
  assign edge_pulse = pulse_q;
  assign status     = status_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench: expected edge pulses are queued with their cycle of arrival and a
// negedge monitor pops and checks them; level/status/irq are checked inline.
module tb_multi_edge_detector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  level_in;
  logic [15:0] mode;
  logic [7:0]  irq_en;
  logic [7:0]  clr;
  logic [7:0]  filt_level;
  logic [7:0]  edge_pulse;
  logic [7:0]  status;
  logic        irq;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  multi_edge_detector #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .FILT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .level_in(level_in),
    .mode(mode),
    .irq_en(irq_en),
    .clr(clr),
    .filt_level(filt_level),
    .edge_pulse(edge_pulse),
    .status(status),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A pulse launched by an input change driven now appears 6 rising edges later.
  task automatic expect_pulse(input logic [7:0] val);
    exp_t e;
    e.cyc = cyc + 6;
    e.val = val;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (edge_pulse !== 8'h00) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got %0h at cycle %0d expected none", edge_pulse, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.val !== edge_pulse) begin
          n_err++;
          $display("FAIL pulse: got %0h at cycle %0d expected %0h at cycle %0d",
                   edge_pulse, cyc, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    level_in = 8'h00;
    mode     = 16'h0000;
    irq_en   = 8'h00;
    clr      = 8'h00;
    tick(3);
    chk("rst_filt",   32'(filt_level), 32'h00);
    chk("rst_pulse",  32'(edge_pulse), 32'h00);
    chk("rst_status", 32'(status),     32'h00);
    chk("rst_irq",    32'(irq),        32'h0);
    reset_n = 1'b1;
    tick(3);

    // Channel 0 rising edge, irq enabled
    mode[1:0] = 2'b01;
    irq_en    = 8'h01;
    level_in[0] = 1'b1;
    expect_pulse(8'h01);
    tick(5);
    chk("t1_filt_early", 32'(filt_level), 32'h00);
    tick(1);
    chk("t1_filt", 32'(filt_level), 32'h01);
    tick(1);
    chk("t1_status", 32'(status), 32'h01);
    chk("t1_irq_early", 32'(irq), 32'h0);
    tick(1);
    chk("t1_irq", 32'(irq), 32'h1);
    clr = 8'h01;
    tick(1);
    clr = 8'h00;
    chk("t1_clr_status", 32'(status), 32'h00);
    chk("t1_clr_irq_hold", 32'(irq), 32'h1);
    tick(1);
    chk("t1_clr_irq", 32'(irq), 32'h0);

    // Channel 1 glitch of 3 clocks must be rejected
    mode[3:2] = 2'b11;
    level_in[1] = 1'b1;
    tick(3);
    level_in[1] = 1'b0;
    tick(8);
    chk("t2_filt", 32'(filt_level), 32'h01);
    chk("t2_status", 32'(status), 32'h00);

    // Channel 2 falling-only mode: 0->1->0 with 10-clock holds
    mode[5:4] = 2'b10;
    level_in[2] = 1'b1;
    tick(10);
    chk("t3_filt_rise", 32'(filt_level), 32'h05);
    chk("t3_status_rise", 32'(status), 32'h00);
    level_in[2] = 1'b0;
    expect_pulse(8'h04);
    tick(10);
    chk("t3_filt_fall", 32'(filt_level), 32'h01);
    chk("t3_status_fall", 32'(status), 32'h04);
    clr = 8'h04;
    tick(1);
    clr = 8'h00;
    tick(1);

    // Channel 3: set wins over a coincident clear
    mode[7:6] = 2'b11;
    irq_en    = 8'h09;
    level_in[3] = 1'b1;
    expect_pulse(8'h08);
    tick(7);
    chk("t4_status_set", 32'(status), 32'h08);
    tick(1);
    chk("t4_irq_set", 32'(irq), 32'h1);
    level_in[3] = 1'b0;
    expect_pulse(8'h08);
    tick(6);
    clr = 8'h08;
    tick(1);
    chk("t4_set_wins", 32'(status), 32'h08);
    tick(1);
    clr = 8'h00;
    chk("t4_clr_alone", 32'(status), 32'h00);
    chk("t4_irq_hold", 32'(irq), 32'h1);
    tick(1);
    chk("t4_irq_drop", 32'(irq), 32'h0);

    // All channels toggle together
    mode = 16'hFFFF;
    level_in = ~level_in;
    expect_pulse(8'hFF);
    tick(6);
    chk("t5_filt", 32'(filt_level), 32'hFE);
    tick(1);
    chk("t5_status", 32'(status), 32'hFF);
    clr = 8'hFF;
    tick(1);
    clr = 8'h00;
    tick(1);
    chk("t5_irq", 32'(irq), 32'h0);

    // Reset mid-filter discards progress; channel 0 re-filters from scratch after release
    level_in = 8'h01;
    tick(4);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_filt",   32'(filt_level), 32'h00);
    chk("t6_rst_pulse",  32'(edge_pulse), 32'h00);
    chk("t6_rst_status", 32'(status),     32'h00);
    chk("t6_rst_irq",    32'(irq),        32'h0);
    tick(2);
    reset_n = 1'b1;
    expect_pulse(8'h01);
    tick(5);
    chk("t6_refilt_early", 32'(filt_level), 32'h00);
    tick(1);
    chk("t6_refilt", 32'(filt_level), 32'h01);
    tick(1);
    chk("t6_status", 32'(status), 32'h01);

    tick(10);
    chk("pending_pulses", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
